// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_AW = 32;
  localparam int unsigned DMEM_DW = 32;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LOAD = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating loader wait counter. sat is high once the loader has been
// refused for MAX_WAIT consecutive arbitration cycles.
module dmem_arb_starve_cnt #(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX_W))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sat = (cnt_q == MAX_W);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port (core MEM stage vs
// loader/debug). Grants one access per cycle, muxes address/data/we onto the
// memory, and returns read data one cycle after the grant.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; when
// undefined the core has fixed priority with a loader starvation counter.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = DMEM_AW,
  parameter int unsigned DW       = DMEM_DW,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_o
);

  arb_state_e    state_q, state_d;
  logic          load_wins;
  logic          c_rvalid_q, c_rvalid_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] l_rdata_q, l_rdata_d;

`ifdef DMEM_ARB_RR_EN
  owner_e last_q, last_d;

  assign load_wins = (last_q == OWN_CORE);

  // Track the most recent owner; any grant, including in LOCK, updates it.
  always_comb begin
    last_d = last_q;
    if (c_gnt)      last_d = OWN_CORE;
    else if (l_gnt) last_d = OWN_LOAD;
  end

  // Last-owner register.
  always_ff @(posedge clk) begin
    if (rst) last_q <= OWN_CORE;
    else     last_q <= last_d;
  end
`else
  logic wait_inc;
  logic wait_clr;
  logic wait_sat;

  assign wait_inc  = (state_q == ST_ARB) & l_req & ~l_gnt;
  assign wait_clr  = l_gnt | ~l_req;
  assign load_wins = wait_sat;

  dmem_arb_starve_cnt #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .clk(clk),
    .rst(rst),
    .inc(wait_inc),
    .clr(wait_clr),
    .sat(wait_sat)
  );
`endif

  // Grant decision and ARB/LOCK next state.
  always_comb begin
    state_d = state_q;
    c_gnt   = 1'b0;
    l_gnt   = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        l_gnt = l_req & (~c_req | load_wins);
        c_gnt = c_req & ~l_gnt;
        if (l_gnt && l_lock) state_d = ST_LOCK;
      end
      ST_LOCK: begin
        l_gnt = l_req;
        if (!l_lock) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Memory-side mux: idle port parks on the core address with no write.
  always_comb begin
    mem_addr  = c_addr;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_we    = l_we;
    end else if (c_gnt) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = c_we;
    end
  end

  // Read return: capture memory data for a granted read, else hold.
  always_comb begin
    c_rvalid_d = c_gnt & ~c_we;
    l_rvalid_d = l_gnt & ~l_we;
    c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
    l_rdata_d  = l_rvalid_d ? mem_rdata : l_rdata_q;
  end

  // State and read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      c_rvalid_q <= c_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign l_rdata  = l_rdata_q;
  assign stall_o  = c_req & ~c_gnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a read-data scoreboard and a
// small behavioural memory on the port.
module tb_dmem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          l_req, l_we, l_lock;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt, l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_o;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] c_q[$];
  logic [DW-1:0] l_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_fail   = 0;

  dmem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(8), .WAIT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] = mem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Combinational grant checks, taken at the falling edge.
  task automatic gnts(input string tag, input logic ec, input logic el, input logic es);
    @(negedge clk);
    chk({tag, ".c_gnt"}, 64'(c_gnt), 64'(ec));
    chk({tag, ".l_gnt"}, 64'(l_gnt), 64'(el));
    chk({tag, ".stall"}, 64'(stall_o), 64'(es));
  endtask

  // Advance one clock and score the read-return registers.
  task automatic tick(input string tag);
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    chk({tag, ".c_rvalid"}, 64'(c_rvalid), 64'(c_q.size() != 0));
    chk({tag, ".l_rvalid"}, 64'(l_rvalid), 64'(l_q.size() != 0));
    if (c_q.size() != 0) begin
      e = c_q.pop_front();
      chk({tag, ".c_rdata"}, 64'(c_rdata), 64'(e));
    end
    if (l_q.size() != 0) begin
      e = l_q.pop_front();
      chk({tag, ".l_rdata"}, 64'(l_rdata), 64'(e));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'hA;
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_lock = 0; l_addr = '0; l_wdata = '0;

    // Reset state
    gnts("rst", 0, 0, 0);
    chk("rst.mem_we", 64'(mem_we), 64'd0);
    tick("rst");
    chk("rst.c_rdata", 64'(c_rdata), 64'd0);
    chk("rst.l_rdata", 64'(l_rdata), 64'd0);
    #1 rst = 1'b0;

    // 1: core read of addr 4
    c_req = 1; c_we = 0; c_addr = 32'h4;
    c_q.push_back(32'hA);
    gnts("t1", 1, 0, 0);
    chk("t1.mem_addr", 64'(mem_addr), 64'h4);
    chk("t1.mem_we", 64'(mem_we), 64'd0);
    tick("t1");
    c_req = 0; c_addr = 32'h6C;
    gnts("t1idle", 0, 0, 0);
    chk("t1idle.mem_addr", 64'(mem_addr), 64'h6C);
    chk("t1idle.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("t1idle.mem_we", 64'(mem_we), 64'd0);
    tick("t1idle");
    chk("t1idle.c_rdata_hold", 64'(c_rdata), 64'hA);

`ifndef DMEM_ARB_RR_EN
    // 2: both write every cycle; loader starves for MAX_WAIT cycles
    c_req = 1; c_we = 1; c_addr = 32'h20; c_wdata = 32'h100;
    l_req = 1; l_we = 1; l_addr = 32'h30; l_wdata = 32'h300;
    for (int i = 0; i < 8; i++) begin
      gnts($sformatf("t2.c%0d", i), 1, 0, 0);
      tick($sformatf("t2.c%0d", i));
    end
    gnts("t2.l", 0, 1, 1);
    chk("t2.l.mem_addr", 64'(mem_addr), 64'h30);
    chk("t2.l.mem_wdata", 64'(mem_wdata), 64'h300);
    chk("t2.l.mem_we", 64'(mem_we), 64'd1);
    tick("t2.l");
    gnts("t2.after", 1, 0, 0);
    tick("t2.after");
    c_req = 0; l_req = 0;
    tick("t2.idle");
`endif

    // 3: loader lock for 4 cycles while the core waits
    l_req = 1; l_we = 0; l_addr = 32'h4; l_lock = 1;
    l_q.push_back(32'hA);
    gnts("t3.grab", 0, 1, 0);
    tick("t3.grab");
    c_req = 1; c_we = 0; c_addr = 32'h4;
    l_we = 1; l_addr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      l_wdata = 32'h200 + DW'(k);
      gnts($sformatf("t3.lock%0d", k), 0, 1, 1);
      chk($sformatf("t3.lock%0d.mem_wdata", k), 64'(mem_wdata), 64'h200 + 64'(k));
      tick($sformatf("t3.lock%0d", k));
    end
    l_lock = 0; l_wdata = 32'h2FF;
    gnts("t3.release", 0, 1, 1);
    tick("t3.release");
    l_req = 0;
    c_q.push_back(32'hA);
    gnts("t3.core", 1, 0, 0);
    tick("t3.core");
    c_req = 0;

    // 4: reset while in LOCK with a loader read in flight
    l_req = 1; l_we = 0; l_addr = 32'h4; l_lock = 1;
    l_q.push_back(32'hA);
    gnts("t4.grab", 0, 1, 0);
    tick("t4.grab");
    rst = 1;
    gnts("t4.inlock", 0, 1, 0);
    tick("t4.rst");
    chk("t4.l_rdata", 64'(l_rdata), 64'd0);
    rst = 0; l_req = 0; l_lock = 0;
    c_req = 1; c_we = 0; c_addr = 32'h4;
    c_q.push_back(32'hA);
    gnts("t4.core", 1, 0, 0);
    tick("t4.core");
    c_req = 0;

`ifndef DMEM_ARB_RR_EN
    // 6: simultaneous writes to the same address
    c_req = 1; c_we = 1; c_addr = 32'h8; c_wdata = 32'h55;
    l_req = 1; l_we = 1; l_addr = 32'h8; l_wdata = 32'h77;
    gnts("t6.c", 1, 0, 0);
    chk("t6.c.mem_we", 64'(mem_we), 64'd1);
    chk("t6.c.mem_wdata", 64'(mem_wdata), 64'h55);
    tick("t6.c");
    c_req = 0;
    gnts("t6.l", 0, 1, 0);
    chk("t6.l.mem_wdata", 64'(mem_wdata), 64'h77);
    chk("t6.l.mem_addr", 64'(mem_addr), 64'h8);
    tick("t6.l");
    l_req = 0;
    c_req = 1; c_we = 0; c_addr = 32'h8;
    c_q.push_back(32'h77);
    gnts("t6.rd", 1, 0, 0);
    tick("t6.rd");
    c_req = 0;
`else
    // 5: round-robin from reset, both writing continuously
    rst = 1;
    tick("t5.rst");
    rst = 0;
    c_req = 1; c_we = 1; c_addr = 32'h20; c_wdata = 32'h1;
    l_req = 1; l_we = 1; l_addr = 32'h30; l_wdata = 32'h2;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) gnts($sformatf("t5.%0d", i), 0, 1, 1);
      else            gnts($sformatf("t5.%0d", i), 1, 0, 0);
      tick($sformatf("t5.%0d", i));
    end
    c_req = 0; l_req = 0;
`endif

    tick("end");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
